// File: rtl/encoder4_2_seq.sv
// Registered 4-to-2 priority encoder with a one-deep valid/ready output buffer.
// It also keeps a saturating count of accepted multi-hot words.
module encoder4_2_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] y,
  output logic       zero,
  output logic       multi,
  input  logic       err_clr,
  output logic [7:0] err_cnt
);

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              accept, drain;
  logic [1:0]        y_p1;
  logic              zero_p1, multi_p1;
  logic [CNT_W-1:0]  err_cnt_p1;

  function automatic logic [1:0] enc_prio(input logic [DATA_W-1:0] c);
    if (c[3])      return 2'b11;
    else if (c[2]) return 2'b10;
    else if (c[1]) return 2'b01;
    else           return 2'b00;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic is_multi(input logic [DATA_W-1:0] c);
    return (c & (c - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 8'd1;
  endfunction

  assign out_valid = (state_q == FULL);
  assign in_ready  = (state_q == EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Stage p1: result register, loaded only on accept and otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1     <= 2'b00;
      zero_p1  <= 1'b0;
      multi_p1 <= 1'b0;
    end else if (accept) begin
      y_p1     <= enc_prio(in_code);
      zero_p1  <= (in_code == 4'b0000);
      multi_p1 <= is_multi(in_code);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_cnt_p1 <= '0;
    else if (err_clr)                     err_cnt_p1 <= '0;
    else if (accept && is_multi(in_code)) err_cnt_p1 <= sat_inc(err_cnt_p1);
  end

  assign y       = y_p1;
  assign zero    = zero_p1;
  assign multi   = multi_p1;
  assign err_cnt = err_cnt_p1;

endmodule
